stage_data_tx: RTL and testbench
================================

Name: stage_data_tx

Overview:
- Transmit end of the stage input-data stream (st_data / st_data_vld / st_data_fst / st_data_rdy).
- Buffers words from an upstream producer in a 16-entry FIFO, then issues gap-free bursts of burst_length+1 words to a stage controller.
- First word of each burst is flagged with fst; the downstream stage counts words per burst with the same length encoding.
- Sits between the host/previous-layer data source and the stage input port.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth (16 words)
DATA_W, 32, word width (float_24_8 packed, 32 bits)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
in_data  in  DATA_W  upstream write data
in_vld  in  1  upstream write valid
in_rdy  out  1  FIFO can accept a word
burst_length  in  3  words per burst minus 1; same encoding as load_length
enable  in  1  allows new bursts to start
st_data  out  DATA_W  stream data to stage (float_24_8)
st_data_vld  out  1  stream valid
st_data_fst  out  1  first word of burst
st_data_rdy  in  1  stage accepts word
fifo_level  out  DEPTH_LOG2+1  FIFO occupancy, 0..16
burst_count  out  12  completed bursts, wrapping
busy  out  1  FSM in SEND

Behaviour:
- Reset (asynchronous, active-high) clears all state immediately:
  - rd_ptr = wr_ptr = 0, fifo_level = 0, state IDLE.
  - beat_cnt = 0, len_q = 0, burst_count = 0.
  - Outputs: st_data_vld = 0, st_data_fst = 0, st_data = 0, busy = 0, in_rdy = 1.
  - FIFO storage is not reset.
- Write side:
  - push = in_vld & in_rdy; in_rdy = (fifo_level != 16).
  - A word pushed in cycle N is counted in fifo_level from N+1.
  - in_vld while full is ignored; data is not stored and state is unchanged.
- Read side:
  - pop = st_data_vld & st_data_rdy.
  - st_data = head entry mem[rd_ptr] when st_data_vld, else 0.
  - Head is stable while st_data_vld & !st_data_rdy.
- Occupancy:
  - push & pop in the same cycle leaves fifo_level unchanged.
  - Pointers wrap modulo 16.
- FSM, IDLE to SEND:
  - Condition: enable & (fifo_level >= burst_length+1).
  - On that edge: len_q <= burst_length, beat_cnt <= 0.
  - st_data_vld goes high the cycle after the condition is true (1-cycle latency).
- FSM, SEND:
  - st_data_vld = 1 and busy = 1.
  - st_data_fst = (beat_cnt == 0).
  - On pop with beat_cnt < len_q: beat_cnt++.
- FSM, end of burst (pop with beat_cnt == len_q):
  - burst_count++, wrapping 4095 -> 0.
  - beat_cnt <= 0.
  - Next state is SEND if enable & (fifo_level − 1 + push >= burst_length+1); new len_q is sampled at this point, giving back-to-back bursts with no idle cycle. Otherwise IDLE.
- Burst commitment:
  - A burst starts only when all its words are already buffered, so st_data_vld never drops mid-burst.
  - enable deasserted mid-burst: the current burst completes.
  - burst_length changed mid-burst: ignored until the next burst start.
- Backpressure: st_data_rdy low holds st_data, st_data_fst and beat_cnt; there is no timeout.
- Reset mid-burst: vld drops asynchronously and buffered words are discarded.
- fifo_level is the registered count; it is never > 16 and never decremented below 0.

Test Plan:
1. burst_length=3; push 1,2,3,4; enable=1; rdy=1 -> vld for 4 consecutive cycles with data 1..4, fst only on word 1; then burst_count=1, busy=0, fifo_level=0.
2. burst_length=3; push 3 words, enable=1 -> vld stays 0. Push a 4th word -> vld rises 1 cycle after fifo_level reaches 4.
3. Backpressure: 4-word burst with rdy pattern 1,0,0,1,1,1 -> word 2 held for 3 cycles, burst finishes on cycle 6, fst asserted only while word 1 is presented.
4. Full: push 20 words with enable=0 -> in_rdy=0 once level=16 and words 17..20 are lost. Then enable=1, burst_length=7 -> two back-to-back 8-word bursts (fst on words 1 and 9, no gap), burst_count=2.
5. Change burst_length from 3 to 1 during beat 2 -> current burst still sends 4 words; next burst sends 2 words.
6. Assert reset during beat 1 of a burst -> st_data_vld=0 in the same cycle; fifo_level=0, burst_count=0; no output after reset until new data is pushed.

Source files
------------

// File: rtl/stage_data_tx.sv
// stage_data_tx: 16-entry FIFO feeding gap-free, fst-flagged bursts to the stage input port
module stage_data_tx #(
   parameter int DEPTH_LOG2 = 4,
   parameter int DATA_W     = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_W-1:0]     in_data,
   input  logic                  in_vld,
   output logic                  in_rdy,
   input  logic [2:0]            burst_length,
   input  logic                  enable,
   output logic [DATA_W-1:0]     st_data,
   output logic                  st_data_vld,
   output logic                  st_data_fst,
   input  logic                  st_data_rdy,
   output logic [DEPTH_LOG2:0]   fifo_level,
   output logic [11:0]           burst_count,
   output logic                  busy
);
   localparam int CW = DEPTH_LOG2 + 2;
   localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(1 << DEPTH_LOG2);
   typedef enum logic {IDLE, SEND} state_t;
   state_t state, state_nxt;
   logic [DATA_W-1:0] mem [1 << DEPTH_LOG2];
   logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic [2:0] beat_cnt, len_q;
   logic push, pop, last_beat, start_ok, cont_ok;
   logic [CW-1:0] need, avail_after;
   assign in_rdy      = fifo_level != FULL;
   assign push        = in_vld & in_rdy;
   assign pop         = st_data_vld & st_data_rdy;
   assign last_beat   = pop & (beat_cnt == len_q);
   assign need        = CW'(burst_length) + CW'(1);
   // words left once this cycle's pop and push land; decides back-to-back bursts
   assign avail_after = {1'b0, fifo_level} - CW'(1) + CW'(push);
   assign start_ok    = enable & ({1'b0, fifo_level} >= need);
   assign cont_ok     = enable & (avail_after >= need);
   // state register
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   // next state: a burst only starts when all of its words are already buffered
   always_comb
      state_nxt = (state == IDLE) ? (start_ok ? SEND : IDLE) : ((last_beat && !cont_ok) ? IDLE : SEND);
   // outputs decoded from state; data forced to zero when not valid
   always_comb begin
      st_data_vld = state == SEND;
      busy        = state == SEND;
      st_data_fst = (state == SEND) && (beat_cnt == 3'd0);
      st_data     = (state == SEND) ? mem[rd_ptr] : '0;
   end
   // FIFO storage is deliberately left unreset
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= in_data;
   // pointers, occupancy, beat tracking and burst counter
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fifo_level  <= '0;
         beat_cnt    <= '0;
         len_q       <= '0;
         burst_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
         if (pop) rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
         fifo_level <= fifo_level + (DEPTH_LOG2 + 1)'(push) - (DEPTH_LOG2 + 1)'(pop);
         if ((state == IDLE && start_ok) || (last_beat && cont_ok)) len_q <= burst_length;
         if (state == IDLE || last_beat) beat_cnt <= '0;
         else if (pop) beat_cnt <= beat_cnt + 3'd1;
         if (last_beat) burst_count <= burst_count + 12'd1;
      end
endmodule

// File: tb/tb_stage_data_tx.sv
// tb_stage_data_tx: random and directed stimulus checked against a queue-based burst model
module tb_stage_data_tx;
   logic clk = 0, reset = 1;
   logic [31:0] in_data = 0;
   logic in_vld = 0, enable = 0, st_data_rdy = 0;
   logic [2:0] burst_length = 0;
   logic in_rdy, st_data_vld, st_data_fst, busy;
   logic [31:0] st_data;
   logic [4:0] fifo_level;
   logic [11:0] burst_count;
   int total = 0, bad = 0;
   logic [31:0] q[$];
   bit active = 0;
   int sent = 0, blen = 0, bursts = 0;

   stage_data_tx dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
      .burst_length(burst_length), .enable(enable), .st_data(st_data),
      .st_data_vld(st_data_vld), .st_data_fst(st_data_fst), .st_data_rdy(st_data_rdy),
      .fifo_level(fifo_level), .burst_count(burst_count), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic compare_all();
      check("vld", 32'(st_data_vld), 32'(active));
      check("busy", 32'(busy), 32'(active));
      check("fst", 32'(st_data_fst), 32'(active && sent == 0));
      check("data", st_data, (active && q.size() > 0) ? q[0] : 32'd0);
      check("in_rdy", 32'(in_rdy), 32'(q.size() < 16));
      check("level", 32'(fifo_level), 32'(q.size()));
      check("bursts", 32'(burst_count), 32'(bursts));
   endtask

   task automatic model_reset();
      q.delete();
      active = 0;
      sent = 0;
      blen = 0;
      bursts = 0;
   endtask

   task automatic step(input bit v, input bit en, input bit r, input logic [2:0] bl);
      bit push, pop;
      int sz;
      @(negedge clk);
      in_vld = v;
      in_data = $urandom;
      enable = en;
      st_data_rdy = r;
      burst_length = bl;
      #1;
      compare_all();
      sz = q.size();
      push = v && sz < 16;
      pop = active && r;
      if (!active) begin
         if (en && sz >= int'(bl) + 1) begin
            active = 1;
            blen = int'(bl);
            sent = 0;
         end
      end else if (pop) begin
         if (sent == blen) begin
            bursts = (bursts + 1) % 4096;
            sent = 0;
            if (en && sz - 1 + int'(push) >= int'(bl) + 1) blen = int'(bl);
            else active = 0;
         end else sent++;
      end
      if (pop) void'(q.pop_front());
      if (push) q.push_back(in_data);
   endtask

   initial begin
      #1;
      compare_all();
      @(negedge clk);
      reset = 0;
      for (int i = 0; i < 4; i++) step(1, 0, 1, 3);
      for (int i = 0; i < 8; i++) step(0, 1, 1, 3);
      for (int i = 0; i < 3; i++) step(1, 1, 1, 3);
      for (int i = 0; i < 3; i++) step(0, 1, 1, 3);
      step(1, 1, 1, 3);
      for (int i = 0; i < 6; i++) step(0, 1, 1, 3);
      for (int i = 0; i < 4; i++) step(1, 0, 1, 3);
      step(0, 1, 1, 3);
      step(0, 1, 1, 3);
      step(0, 1, 0, 3);
      step(0, 1, 0, 3);
      for (int i = 0; i < 6; i++) step(0, 1, 1, 3);
      for (int i = 0; i < 20; i++) step(1, 0, 1, 7);
      for (int i = 0; i < 20; i++) step(0, 1, 1, 7);
      for (int i = 0; i < 8; i++) step(1, 0, 1, 3);
      step(0, 1, 1, 3);
      step(0, 1, 1, 3);
      step(0, 1, 1, 1);
      for (int i = 0; i < 10; i++) step(0, 1, 1, 1);
      for (int p = 0; p < 4; p++)
         for (int i = 0; i < 800; i++)
            step($urandom_range(99) < 30 + 20 * p, $urandom_range(99) < 85,
                 $urandom_range(99) < 90 - 20 * p, 3'($urandom_range(7)));
      for (int i = 0; i < 16; i++) step(1, 0, 1, 2);
      for (int i = 0; i < 5 && !(active && sent == 1); i++) step(0, 1, 1, 2);
      @(negedge clk);
      reset = 1;
      #1;
      model_reset();
      compare_all();
      @(negedge clk);
      reset = 0;
      for (int i = 0; i < 6; i++) step(0, 1, 1, 0);
      step(1, 1, 1, 0);
      for (int i = 0; i < 4; i++) step(0, 1, 1, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
